// File: rtl/uart_rx_frame_if.sv
// uart_rx_frame_if: one-entry valid/ready holding register carrying received bytes
interface uart_rx_frame_if;
    logic [7:0] data_out;
    logic       rx_valid;
    logic       rx_ready;
    modport master (output data_out, rx_valid, input rx_ready);
    modport slave  (input data_out, rx_valid, output rx_ready);
endinterface

// File: rtl/uart_rx_frame.sv
// uart_rx_frame: 8-bit UART receiver with optional parity, glitch rejection and overrun/framing/parity flags
module uart_rx_frame #(
    parameter int BAUD_RATE  = 24,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic            clk,
    input  logic            srst,
    input  logic            rxd,
    uart_rx_frame_if.master rx,
    output logic            busy,
    output logic            frame_err,
    output logic            parity_err,
    output logic            overrun
);
    localparam int CW = $clog2(BAUD_RATE);
    localparam logic [CW-1:0] HALF = CW'(BAUD_RATE / 2 - 1);
    localparam logic [CW-1:0] LAST = CW'(BAUD_RATE - 1);
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
    state_t        state, state_nx;
    logic [1:0]    sync;
    logic          rxd_s, rxd_d, fall, stop_end, deliver;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    bit_idx, bit_idx_nx;
    logic [7:0]    shreg, shreg_nx;
    logic          par_bad, par_bad_nx;
    assign rxd_s    = sync[1];
    assign fall     = rxd_d & ~rxd_s;
    assign busy     = state != IDLE;
    assign stop_end = state == STOP && cnt == LAST;
    assign deliver  = stop_end && rxd_s && !par_bad;
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt + 1'b1;
        bit_idx_nx = bit_idx;
        shreg_nx   = shreg;
        par_bad_nx = par_bad;
        case (state)
            IDLE: begin
                cnt_nx   = '0;
                state_nx = fall ? START : IDLE;
            end
            START: if (cnt == HALF) begin
                cnt_nx     = '0;
                bit_idx_nx = '0;
                par_bad_nx = 1'b0;
                state_nx   = rxd_s ? IDLE : DATA;
            end
            DATA: if (cnt == LAST) begin
                cnt_nx     = '0;
                shreg_nx   = {rxd_s, shreg[7:1]};
                bit_idx_nx = bit_idx + 1'b1;
                if (bit_idx == 3'd7) state_nx = PARITY_EN ? PARITY : STOP;
            end
            PARITY: if (cnt == LAST) begin
                cnt_nx     = '0;
                par_bad_nx = ^shreg ^ rxd_s ^ PARITY_ODD;
                state_nx   = STOP;
            end
            STOP: if (cnt == LAST) begin
                cnt_nx   = '0;
                state_nx = rxd_s ? IDLE : BREAK;
            end
            BREAK: begin
                cnt_nx   = '0;
                state_nx = rxd_s ? IDLE : BREAK;
            end
            default: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk) begin
        if (srst) begin
            sync        <= 2'b11;
            rxd_d       <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= '0;
            shreg       <= '0;
            par_bad     <= 1'b0;
            rx.data_out <= '0;
            rx.rx_valid <= 1'b0;
            frame_err   <= 1'b0;
            parity_err  <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            sync       <= {sync[0], rxd};
            rxd_d      <= rxd_s;
            state      <= state_nx;
            cnt        <= cnt_nx;
            bit_idx    <= bit_idx_nx;
            shreg      <= shreg_nx;
            par_bad    <= par_bad_nx;
            frame_err  <= stop_end && !rxd_s;
            parity_err <= stop_end && rxd_s && par_bad;
            // a same-cycle handshake frees the holder, so the new byte may replace the old one
            if (deliver && (!rx.rx_valid || rx.rx_ready)) begin
                rx.data_out <= shreg;
                rx.rx_valid <= 1'b1;
            end else begin
                if (deliver) overrun <= 1'b1;
                if (rx.rx_valid && rx.rx_ready) rx.rx_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_uart_rx_frame.sv
// tb_uart_rx_frame: directed frames against an 8N1 receiver and an even-parity receiver
module tb_uart_rx_frame;
    localparam int B = 24;
    logic clk = 1'b0, srst = 1'b1, rxd0 = 1'b1, rxd1 = 1'b1;
    logic busy0, fe0, pe0, ov0, busy1, fe1, pe1, ov1;
    uart_rx_frame_if rx0();
    uart_rx_frame_if rx1();
    int n_checks = 0, n_errs = 0, cyc = 0;
    int rise0 = 0, hi0 = 0, nfe0 = 0, npe0 = 0, t_rise0 = 0;
    int rise1 = 0, nfe1 = 0, npe1 = 0;
    int b, h, ts;
    logic [7:0] last0 = '0, last1 = '0;
    logic pv0 = 1'b0, pv1 = 1'b0, bseen0 = 1'b0;
    always #5 clk = ~clk;
    uart_rx_frame #(.BAUD_RATE(B)) dut0 (
        .clk(clk), .srst(srst), .rxd(rxd0), .rx(rx0),
        .busy(busy0), .frame_err(fe0), .parity_err(pe0), .overrun(ov0));
    uart_rx_frame #(.BAUD_RATE(B), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut1 (
        .clk(clk), .srst(srst), .rxd(rxd1), .rx(rx1),
        .busy(busy1), .frame_err(fe1), .parity_err(pe1), .overrun(ov1));
    always @(negedge clk) begin
        cyc++;
        if (rx0.rx_valid && !pv0) begin rise0++; t_rise0 = cyc; end
        if (rx0.rx_valid) hi0++;
        if (rx0.rx_valid && rx0.rx_ready) last0 = rx0.data_out;
        if (fe0) nfe0++;
        if (pe0) npe0++;
        if (busy0) bseen0 = 1'b1;
        if (rx1.rx_valid && !pv1) rise1++;
        if (rx1.rx_valid && rx1.rx_ready) last1 = rx1.data_out;
        if (fe1) nfe1++;
        if (pe1) npe1++;
        pv0 = rx0.rx_valid;
        pv1 = rx1.rx_valid;
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic wait_clk(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask
    task automatic set_line(input int ln, input logic v);
        if (ln == 0) rxd0 = v;
        else rxd1 = v;
    endtask
    task automatic send(input int ln, input logic [7:0] d, input bit pen, input bit pbit, input bit sv, input int sl);
        set_line(ln, 1'b0);
        wait_clk(B);
        for (int i = 0; i < 8; i++) begin
            set_line(ln, d[i]);
            wait_clk(B);
        end
        if (pen) begin
            set_line(ln, pbit);
            wait_clk(B);
        end
        set_line(ln, sv);
        wait_clk(sl);
        set_line(ln, 1'b1);
    endtask
    initial begin
        rx0.rx_ready = 1'b1;
        rx1.rx_ready = 1'b1;
        wait_clk(5);
        check("rst_data", rx0.data_out, 8'h00);
        check("rst_valid", rx0.rx_valid, 1'b0);
        check("rst_busy", busy0, 1'b0);
        check("rst_flags", {fe0, pe0, ov0}, 3'b000);
        srst = 1'b0;
        wait_clk(5);
        b = rise0; h = hi0; ts = cyc;
        send(0, 8'hA5, 1'b0, 1'b0, 1'b1, B);
        wait_clk(5);
        check("a5_data", last0, 8'hA5);
        check("a5_rise", rise0 - b, 1);
        check("a5_pulse", hi0 - h, 1);
        check("a5_lat", (t_rise0 - ts >= 228 && t_rise0 - ts <= 234), 1'b1);
        check("a5_flags", nfe0 + npe0 + ov0, 0);
        bseen0 = 1'b0; b = rise0;
        rxd0 = 1'b0;
        wait_clk(5);
        rxd0 = 1'b1;
        wait_clk(40);
        check("gl_busy_seen", bseen0, 1'b1);
        check("gl_idle", busy0, 1'b0);
        check("gl_no_valid", rise0 - b, 0);
        check("gl_flags", nfe0 + npe0, 0);
        b = rise0;
        send(0, 8'h3C, 1'b0, 1'b0, 1'b0, 2 * B);
        wait_clk(5);
        check("fe_count", nfe0, 1);
        check("fe_no_valid", rise0 - b, 0);
        check("fe_idle", busy0, 1'b0);
        send(0, 8'h81, 1'b0, 1'b0, 1'b1, B);
        wait_clk(5);
        check("fe_next_data", last0, 8'h81);
        check("fe_next_rise", rise0 - b, 1);
        send(1, 8'h07, 1'b1, 1'b1, 1'b1, B);
        wait_clk(5);
        check("par_ok_data", last1, 8'h07);
        check("par_ok_rise", rise1, 1);
        check("par_ok_err", npe1, 0);
        send(1, 8'h07, 1'b1, 1'b0, 1'b1, B);
        wait_clk(5);
        check("par_bad_err", npe1, 1);
        check("par_bad_rise", rise1, 1);
        check("par_bad_fe", nfe1, 0);
        rx0.rx_ready = 1'b0;
        send(0, 8'h11, 1'b0, 1'b0, 1'b1, B);
        send(0, 8'h22, 1'b0, 1'b0, 1'b1, B);
        wait_clk(5);
        check("ov_data", rx0.data_out, 8'h11);
        check("ov_valid", rx0.rx_valid, 1'b1);
        check("ov_flag", ov0, 1'b1);
        rx0.rx_ready = 1'b1;
        wait_clk(1);
        rx0.rx_ready = 1'b0;
        wait_clk(1);
        check("ov_cleared", rx0.rx_valid, 1'b0);
        check("ov_xfer_data", last0, 8'h11);
        check("ov_sticky", ov0, 1'b1);
        rx0.rx_ready = 1'b1;
        fork
            send(0, 8'hFF, 1'b0, 1'b0, 1'b1, B);
            begin
                wait_clk(100);
                check("mid_busy", busy0, 1'b1);
                srst = 1'b1;
                wait_clk(1);
                check("mr_busy", busy0, 1'b0);
                check("mr_data", rx0.data_out, 8'h00);
                check("mr_valid", rx0.rx_valid, 1'b0);
                check("mr_flags", {fe0, pe0, ov0}, 3'b000);
                srst = 1'b0;
            end
        join
        wait_clk(5);
        send(0, 8'h5A, 1'b0, 1'b0, 1'b1, B);
        wait_clk(5);
        check("post_rst_data", last0, 8'h5A);
        check("post_rst_out", rx0.data_out, 8'h5A);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
